// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU types: register index and pipeline controller states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } pctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Per-cycle advance/hold/flush sequencer for PC and pipeline latches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            dREN_out_3,
    input  logic            dWEN_out_3,
    input  logic            branch_taken_3,
    input  logic            dREN_out_2,
    input  regbits_t        wsel_out_2,
    input  regbits_t        rs_in_1,
    input  regbits_t        rt_in_1,
    input  logic            uses_rt_1,
    input  logic            halt_out_4,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            memwb_flush,
    output logic            halt,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    pctrl_state_t state_q;
    pctrl_state_t state_d;

    logic dpend;
    logic lu;
    logic stall_inc;
    logic flush_inc;

    assign dpend = (dREN_out_3 | dWEN_out_3) & ~dhit;
    assign lu    = dREN_out_2 & (wsel_out_2 != '0) &
                   ((wsel_out_2 == rs_in_1) | (uses_rt_1 & (wsel_out_2 == rt_in_1)));

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        flush_inc   = 1'b0;

        if (state_q == HALTED) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end else if (halt_out_4) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            state_d = HALTED;
        end else if (dpend) begin
            // Only WB drains; it receives a bubble while memory is busy.
            {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
            memwb_flush = 1'b1;
            state_d     = DWAIT;
        end else begin
            state_d = RUN;
            if (branch_taken_3) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                flush_inc   = 1'b1;
            end else if (lu) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    assign stall_inc = (state_q != HALTED) &&
                       (!(pc_en & ifid_en & idex_en & exmem_en & memwb_en) ||
                        (ifid_flush | idex_flush | exmem_flush | memwb_flush));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halt = (state_q == HALTED);

    sat_counter #(.W(CNTW)) u_stall_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNTW)) u_flush_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Self-checking bench for pipeline_ctrl (16-bit and 4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic       dren3;
        logic       dwen3;
        logic       br;
        logic       dren2;
        logic [4:0] wsel;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       halt4;
    } in_t;

    typedef struct packed {
        in_t        i;
        logic [8:0] exp;   // {pc,ifid,idex,exmem,memwb en ; ifid,idex,exmem,memwb flush}
    } vec_t;

    in_t cur;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
    logic        ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4, halt4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    pipeline_ctrl #(.CNTW(16)) dut (
        .CLK(CLK), .RST(RST), .ihit(cur.ihit), .dhit(cur.dhit),
        .dREN_out_3(cur.dren3), .dWEN_out_3(cur.dwen3), .branch_taken_3(cur.br),
        .dREN_out_2(cur.dren2), .wsel_out_2(cur.wsel), .rs_in_1(cur.rs),
        .rt_in_1(cur.rt), .uses_rt_1(cur.uses_rt), .halt_out_4(cur.halt4),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNTW(4)) dut4 (
        .CLK(CLK), .RST(RST), .ihit(cur.ihit), .dhit(cur.dhit),
        .dREN_out_3(cur.dren3), .dWEN_out_3(cur.dwen3), .branch_taken_3(cur.br),
        .dREN_out_2(cur.dren2), .wsel_out_2(cur.wsel), .rs_in_1(cur.rs),
        .rt_in_1(cur.rt), .uses_rt_1(cur.uses_rt), .halt_out_4(cur.halt4),
        .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4), .exmem_en(exmem_en4),
        .memwb_en(memwb_en4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
        .exmem_flush(exmem_flush4), .memwb_flush(memwb_flush4), .halt(halt4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_halted;
    int m_stall, m_flush;

    function automatic logic [8:0] ref_out(input in_t v);
        logic dp, l;
        dp = (v.dren3 | v.dwen3) & ~v.dhit;
        l  = v.dren2 && (v.wsel != 0) &&
             ((v.wsel == v.rs) || (v.uses_rt && (v.wsel == v.rt)));
        if (v.halt4)  return 9'b00000_0000;
        if (dp)       return 9'b00001_0001;
        if (v.br)     return 9'b11111_1110;
        if (l)        return 9'b00111_0100;
        if (!v.ihit)  return 9'b01111_1000;
        return 9'b11111_0000;
    endfunction

    function automatic logic [8:0] exp_ctl();
        return m_halted ? 9'b0 : ref_out(cur);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/ctl"}, {23'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                             ifid_flush, idex_flush, exmem_flush, memwb_flush}, {23'b0, exp_ctl()});
        chk({tag, "/ctl4"}, {23'b0, pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4,
                              ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4}, {23'b0, exp_ctl()});
        chk({tag, "/halt"}, {30'b0, halt, halt4}, {30'b0, m_halted, m_halted});
        chk({tag, "/stall"}, {16'b0, stall_cnt}, sat(m_stall, 65535));
        chk({tag, "/flush"}, {16'b0, flush_cnt}, sat(m_flush, 65535));
        chk({tag, "/stall4"}, {28'b0, stall_cnt4}, sat(m_stall, 15));
        chk({tag, "/flush4"}, {28'b0, flush_cnt4}, sat(m_flush, 15));
    endtask

    task automatic model_clock();
        logic [8:0] o;
        if (!m_halted) begin
            o = ref_out(cur);
            if (o != 9'b11111_0000) m_stall++;
            if (o == 9'b11111_1110) m_flush++;
            if (cur.halt4) m_halted = 1'b1;
        end
    endtask

    task automatic step(input string tag);
        @(negedge CLK);
        check_all(tag);
        model_clock();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        m_halted = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
        RST = 1'b0;
    endtask

    function automatic in_t idle();
        in_t v;
        v = '0;
        v.ihit = 1'b1;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        in_t v;

        // {ihit,dhit,dren3,dwen3,br,dren2,wsel,rs,rt,uses_rt,halt4}, expected
        tbl[0]  = '{'{1,0,0,0,0,0,5'd0,5'd0,5'd0,0,0}, 9'b11111_0000};
        tbl[1]  = '{'{1,0,1,0,0,0,5'd0,5'd0,5'd0,0,0}, 9'b00001_0001};
        tbl[2]  = '{'{1,1,0,1,0,0,5'd0,5'd0,5'd0,0,0}, 9'b11111_0000};
        tbl[3]  = '{'{1,0,0,0,0,1,5'd8,5'd8,5'd3,0,0}, 9'b00111_0100};
        tbl[4]  = '{'{1,0,0,0,0,1,5'd0,5'd0,5'd0,1,0}, 9'b11111_0000};
        tbl[5]  = '{'{1,0,0,0,0,1,5'd9,5'd2,5'd9,0,0}, 9'b11111_0000};
        tbl[6]  = '{'{1,0,0,0,0,1,5'd9,5'd2,5'd9,1,0}, 9'b00111_0100};
        tbl[7]  = '{'{0,0,0,0,0,0,5'd0,5'd0,5'd0,0,0}, 9'b01111_1000};
        tbl[8]  = '{'{0,0,0,0,1,1,5'd8,5'd8,5'd0,0,0}, 9'b11111_1110};
        tbl[9]  = '{'{1,0,0,1,1,0,5'd0,5'd0,5'd0,0,0}, 9'b00001_0001};
        tbl[10] = '{'{0,0,0,0,0,1,5'd4,5'd1,5'd4,1,0}, 9'b00111_0100};

        cur = idle();
        do_reset();
        step("reset_idle");

        for (int k = 0; k < 11; k++) begin
            do_reset();
            cur = tbl[k].i;
            @(negedge CLK);
            chk($sformatf("tbl%0d", k),
                {23'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush}, {23'b0, tbl[k].exp});
            check_all($sformatf("tbl%0d_model", k));
            model_clock();
            @(posedge CLK);
            #1;
        end

        // Data wait: three frozen cycles, then full advance on dhit
        do_reset();
        cur = idle();
        cur.dren3 = 1'b1;
        for (int k = 0; k < 3; k++) step("dwait");
        cur.dhit = 1'b1;
        step("dwait_done");
        cur = idle();
        @(negedge CLK);
        chk("dwait_stall_cnt", {16'b0, stall_cnt}, 32'd3);

        // Branch held behind a data wait flushes once on the advancing cycle
        do_reset();
        cur = idle();
        cur.br = 1'b1; cur.dwen3 = 1'b1;
        step("br_wait");
        step("br_wait");
        cur.dhit = 1'b1; cur.ihit = 1'b0; cur.dren2 = 1'b1; cur.wsel = 5'd8; cur.rs = 5'd8;
        step("br_adv");
        cur = idle();
        @(negedge CLK);
        chk("br_flush_once", {16'b0, flush_cnt}, 32'd1);

        // Halt is sticky until reset
        do_reset();
        cur = idle();
        cur.halt4 = 1'b1;
        step("halt_in");
        cur = idle();
        for (int k = 0; k < 4; k++) step("halted");
        @(negedge CLK);
        chk("halted_stall_frozen", {16'b0, stall_cnt}, 32'd1);
        do_reset();
        step("post_halt_run");

        // Saturation of the 4-bit counter
        do_reset();
        cur = idle();
        cur.ihit = 1'b0;
        for (int k = 0; k < 20; k++) step("sat");
        @(negedge CLK);
        chk("sat_stall4", {28'b0, stall_cnt4}, 32'd15);
        chk("sat_stall16", {16'b0, stall_cnt}, 32'd20);
        @(posedge CLK);
        #1;

        // Randomized against the reference model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            v.ihit    = ($urandom_range(0, 3) != 0);
            v.dhit    = $urandom_range(0, 1) == 1;
            v.dren3   = ($urandom_range(0, 3) == 0);
            v.dwen3   = ($urandom_range(0, 7) == 0);
            v.br      = ($urandom_range(0, 5) == 0);
            v.dren2   = ($urandom_range(0, 2) == 0);
            v.wsel    = 5'($urandom_range(0, 3));
            v.rs      = 5'($urandom_range(0, 3));
            v.rt      = 5'($urandom_range(0, 3));
            v.uses_rt = $urandom_range(0, 1) == 1;
            v.halt4   = ($urandom_range(0, 79) == 0);
            cur = v;
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
